// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA engine: a CPU write of page XX to $4014 stalls the CPU and copies $XX00-$XXFF into OAMDATA ($2004).
// Optional macro OAM_DMA_ALIGN_EN inserts an ALIGN cycle so the first READ always lands on an even cycle.
module oam_dma_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic [15:0] mem_addr,
    output logic        mem_r_en,
    output logic [7:0]  mem_w_data,
    output logic        cpu_stall,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
`ifdef OAM_DMA_ALIGN_EN
    logic       parity_q, parity_d;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q <= parity_d;
`endif
        end
    end

`ifdef OAM_DMA_ALIGN_EN
    // parity_d is the parity of the upcoming cycle; 0 means that cycle is even.
    always_comb begin
        parity_d = clock_en ? ~parity_q : parity_q;
    end
`endif

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        mem_addr   = cpu_addr;
        mem_r_en   = cpu_r_en;
        mem_w_data = cpu_w_data;

        case (state_q)
            S_IDLE: begin
                // The trigger write itself still reaches the PPU through the pass-through bus.
                if (clock_en && cpu_addr == OAMDMA_ADDR && !cpu_r_en) begin
                    page_d  = cpu_w_data;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end

            S_HALT: begin
                mem_r_en   = 1'b1;
                mem_w_data = '0;
                if (clock_en) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = parity_d ? S_ALIGN : S_READ;
`else
                    state_d = S_READ;
`endif
                end
            end

            S_ALIGN: begin
                mem_r_en   = 1'b1;
                mem_w_data = '0;
                if (clock_en) begin
                    state_d = S_READ;
                end
            end

            S_READ: begin
                mem_addr   = {page_q, idx_q};
                mem_r_en   = 1'b1;
                mem_w_data = '0;
                if (clock_en) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                // mem_r_data holds the byte fetched by the preceding READ cycle.
                mem_addr   = OAMDATA_ADDR;
                mem_r_en   = 1'b0;
                mem_w_data = mem_r_data;
                if (clock_en) begin
                    if (idx_q == 8'hFF) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_READ;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dma_busy  = (state_q != S_IDLE);
        cpu_stall = dma_busy;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized self-checking bench for oam_dma_ctrl: a behavioural cpu_memory plus an expected
// bus-transaction sequence derived from enabled-cycle parity and the page contents.
module tb_oam_dma_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_en;
    logic [15:0] cpu_addr;
    logic        cpu_r_en;
    logic [7:0]  cpu_w_data;
    logic [7:0]  mem_r_data;
    logic [15:0] mem_addr;
    logic        mem_r_en;
    logic [7:0]  mem_w_data;
    logic        cpu_stall;
    logic        dma_busy;

    oam_dma_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .clock_en   (clock_en),
        .cpu_addr   (cpu_addr),
        .cpu_r_en   (cpu_r_en),
        .cpu_w_data (cpu_w_data),
        .mem_r_data (mem_r_data),
        .mem_addr   (mem_addr),
        .mem_r_en   (mem_r_en),
        .mem_w_data (mem_w_data),
        .cpu_stall  (cpu_stall),
        .dma_busy   (dma_busy)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    int         en_cycles;
    logic [7:0] ram [0:65535];
    logic [7:0] oam_log [$];
    logic [7:0] exp_bytes [0:255];

    // Enabled cycles since reset; its LSB is the parity of the cycle being presented.
    always @(posedge clock or posedge reset) begin
        if (reset) en_cycles <= 0;
        else if (clock_en) en_cycles <= en_cycles + 1;
    end

    // cpu_memory model: registered read, OAMDATA writes captured in order.
    always @(posedge clock) begin
        if (clock_en) begin
            if (mem_r_en) mem_r_data <= ram[mem_addr];
            else if (mem_addr == 16'h2004) oam_log.push_back(mem_w_data);
            else ram[mem_addr] = mem_w_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_passthrough(input string tag);
        check({tag, "_addr"}, 32'(mem_addr), 32'(cpu_addr));
        check({tag, "_ren"}, 32'(mem_r_en), 32'(cpu_r_en));
        check({tag, "_wdata"}, 32'(mem_w_data), 32'(cpu_w_data));
        check({tag, "_busy"}, 32'(dma_busy), 32'd0);
        check({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    endtask

    task automatic idle_read();
        cpu_addr   = 16'($urandom_range(0, 16'h3FFF));
        cpu_r_en   = 1'b1;
        cpu_w_data = 8'($urandom);
    endtask

    task automatic fill_page(input logic [7:0] pg, input bit rnd);
        for (int i = 0; i < 256; i++) begin
            exp_bytes[i]      = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
            ram[{pg, 8'(i)}]  = exp_bytes[i];
        end
    endtask

    // Run one transfer. odd selects trigger-cycle parity; gap_at freezes clock_en for 10 cycles
    // at that stall cycle; abort_pair asserts reset at the READ of that byte pair (-1 = never).
    task automatic transfer(input logic [7:0] pg, input bit odd, input int gap_at, input int abort_pair);
        int lead;
        int exp_len;
        int k;
        int guard;
        int j;
        int i;
        logic [15:0] saved_addr;
        logic [7:0]  saved_wd;
        lead = 1;
`ifdef OAM_DMA_ALIGN_EN
        if (odd) lead = 2;
`endif
        exp_len  = 512 + lead;
        clock_en = 1'b1;
        idle_read();
        step();
        if (en_cycles[0] != odd) begin
            idle_read();
            step();
        end
        oam_log.delete();
        cpu_addr   = 16'h4014;
        cpu_r_en   = 1'b0;
        cpu_w_data = pg;
        #1;
        check("trig_addr", 32'(mem_addr), 32'h4014);
        check("trig_ren", 32'(mem_r_en), 32'd0);
        check("trig_wdata", 32'(mem_w_data), 32'(pg));
        check("trig_idle", 32'(dma_busy), 32'd0);
        step();
        // A stray $4014 write while stalled must be ignored.
        cpu_w_data = ~pg;
        #1;
        k = 0;
        guard = 0;
        while (cpu_stall && guard < 2000) begin
            guard++;
            if (abort_pair >= 0 && k == lead + 2 * abort_pair) begin
                reset = 1'b1;
                #1;
                check_passthrough("abort");
                check("abort_partial", 32'(oam_log.size()), 32'(abort_pair));
                @(negedge clock);
                reset = 1'b0;
                idle_read();
                step();
                return;
            end
            if (k < exp_len) begin
                if (k < lead) begin
                    check("dummy_ren", 32'(mem_r_en), 32'd1);
                    check("dummy_addr", 32'(mem_addr), 32'(cpu_addr));
                    check("dummy_wdata", 32'(mem_w_data), 32'd0);
                end else begin
                    j = k - lead;
                    i = j / 2;
                    if (j % 2 == 0) begin
                        check("read_addr", 32'(mem_addr), 32'({pg, 8'(i)}));
                        check("read_ren", 32'(mem_r_en), 32'd1);
                    end else begin
                        check("write_addr", 32'(mem_addr), 32'h2004);
                        check("write_ren", 32'(mem_r_en), 32'd0);
                        check("write_data", 32'(mem_w_data), 32'(exp_bytes[i]));
                    end
                end
            end
            if (k == gap_at) begin
                clock_en   = 1'b0;
                saved_addr = mem_addr;
                saved_wd   = mem_w_data;
                repeat (10) begin
                    step();
                    check("gap_addr", 32'(mem_addr), 32'(saved_addr));
                    check("gap_wdata", 32'(mem_w_data), 32'(saved_wd));
                    check("gap_busy", 32'(dma_busy), 32'd1);
                end
                clock_en = 1'b1;
            end
            idle_read();
            k++;
            step();
        end
        check("stall_guard", 32'(guard < 2000), 32'd1);
        check("stall_len", 32'(k), 32'(exp_len));
        check_passthrough("resume");
        check("oam_count", 32'(oam_log.size()), 32'd256);
        if (oam_log.size() == 256) begin
            for (int b = 0; b < 256; b += 51) check("oam_byte", 32'(oam_log[b]), 32'(exp_bytes[b]));
            check("oam_last", 32'(oam_log[255]), 32'(exp_bytes[255]));
        end
        check("trig_mem", 32'(ram[16'h4014]), 32'(pg));
    endtask

    initial begin
        reset      = 1'b1;
        clock_en   = 1'b1;
        cpu_addr   = 16'h1234;
        cpu_r_en   = 1'b0;
        cpu_w_data = 8'hA5;
        #12;
        check_passthrough("reset");
        @(negedge clock);
        reset = 1'b0;

        // Idle pass-through with random traffic away from $4014.
        repeat (8) begin
            cpu_addr   = 16'($urandom_range(0, 16'h3FFF));
            cpu_r_en   = 1'($urandom);
            cpu_w_data = 8'($urandom);
            #1;
            check_passthrough("idle");
            step();
        end

        fill_page(8'h02, 1'b0);
        transfer(8'h02, 1'b0, -1, -1);
        fill_page(8'h02, 1'b0);
        transfer(8'h02, 1'b1, -1, -1);

        fill_page(8'hFF, 1'b1);
        transfer(8'hFF, 1'($urandom), -1, -1);

        fill_page(8'h04, 1'b1);
        transfer(8'h04, 1'($urandom), -1, 100);
        fill_page(8'h03, 1'b1);
        transfer(8'h03, 1'($urandom), -1, -1);

        fill_page(8'h05, 1'b1);
        transfer(8'h05, 1'b1, 77, -1);
        fill_page(8'h21, 1'b1);
        transfer(8'h21, 1'b0, 300, -1);

        // A read of $4014 never starts a transfer.
        cpu_addr   = 16'h4014;
        cpu_r_en   = 1'b1;
        cpu_w_data = 8'h07;
        repeat (5) begin
            step();
            check("rd4014_busy", 32'(dma_busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
